// File: rtl/imem_arbiter_pkg.sv
// imem_arb_pkg: shared types and default sizing for the instruction-memory
// arbiter (imem_arbiter, imem_starve_ctr, imem_arbiter_if).
//   arb_state_e : priority state of the starvation FSM
//   owner_e     : owner of the read currently in flight
package imem_arb_pkg;

  localparam int DATA_W        = 32;
  localparam int IMEM_DEPTH    = 4096;
  localparam int IMEM_MAX_WAIT = 4;

  typedef enum logic {
    ARB_IF_PRI,
    ARB_LD_PRI
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LD
  } owner_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundles the fetch port, the loader port and the memory port
// of the instruction-memory arbiter. Signal names are given from the arbiter's
// point of view (i_* driven into the arbiter, o_* driven by it).
//   slave  : arbiter side
//   master : requesters / memory side
interface imem_arbiter_if #(
  parameter int IDX_W = 12
);
  // Fetch port
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        i_flush;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  // Loader / debug port
  logic        i_ld_req;
  logic        i_ld_we;
  logic [31:0] i_ld_addr;
  logic [31:0] i_ld_wdata;
  logic        o_ld_gnt;
  logic        o_ld_rvalid;
  logic [31:0] o_ld_rdata;
  // Memory port
  logic             o_mem_en;
  logic             o_mem_we;
  logic [IDX_W-1:0] o_mem_addr;
  logic [31:0]      o_mem_wdata;
  logic [31:0]      i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_flush,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata,
    output o_ld_gnt, o_ld_rvalid, o_ld_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr, i_flush,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata,
    input  o_ld_gnt, o_ld_rvalid, o_ld_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );

endinterface

// File: rtl/imem_arbiter_starve_ctr.sv
// imem_starve_ctr: loader starvation guard. Counts consecutive cycles in which
// the loader requests but is denied; after MAX_WAIT such cycles it raises
// loader priority for exactly one cycle.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_ld_req     : loader is requesting
//   i_ld_gnt     : loader was granted this cycle
//   o_ld_pri     : loader has priority this cycle
module imem_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int MAX_WAIT = IMEM_MAX_WAIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ld_req,
  input  logic i_ld_gnt,
  output logic o_ld_pri
);

  // One extra count value keeps the width >= 1 when MAX_WAIT == 1.
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ARB_IF_PRI;
      r_wait_cnt <= '0;
    end else if (r_state == ARB_LD_PRI) begin
      r_state    <= ARB_IF_PRI;
      r_wait_cnt <= '0;
    end else if (i_ld_req && !i_ld_gnt) begin
      if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
        r_state    <= ARB_LD_PRI;
        r_wait_cnt <= '0;
      end else begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign o_ld_pri = (r_state == ARB_LD_PRI);

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port, registered-read instruction memory
// between the fetch stage (IF) and the program loader (LD). Fetch has default
// priority; imem_starve_ctr guarantees the loader a slot after MAX_WAIT
// consecutive denials. Read data returns one cycle after the grant and is
// steered to whichever requester owned the read; fetch responses can be
// squashed by i_flush in the grant cycle or the response cycle.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : imem_arbiter_if.slave (fetch, loader and memory ports)
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int DEPTH    = IMEM_DEPTH,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int MAX_WAIT = IMEM_MAX_WAIT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  imem_arbiter_if.slave  bus
);

  logic        w_ld_pri;
  logic        w_if_gnt_p0;
  logic        w_ld_gnt_p0;
  logic [31:0] w_addr_p0;
  logic        w_unused_addr_bits;
  owner_e      w_owner_p0;

  owner_e      r_owner_p1;
  logic        r_flush_p1;
  logic        w_if_vld_p1;
  logic        w_ld_vld_p1;

  imem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ld_req (bus.i_ld_req),
    .i_ld_gnt (w_ld_gnt_p0),
    .o_ld_pri (w_ld_pri)
  );

  // ---- p0: grant and memory drive ----
  always_comb begin
    w_if_gnt_p0 = 1'b0;
    w_ld_gnt_p0 = 1'b0;
    if (!i_rst) begin
      if (w_ld_pri) begin
        if (bus.i_ld_req)      w_ld_gnt_p0 = 1'b1;
        else if (bus.i_if_req) w_if_gnt_p0 = 1'b1;
      end else begin
        if (bus.i_if_req)      w_if_gnt_p0 = 1'b1;
        else if (bus.i_ld_req) w_ld_gnt_p0 = 1'b1;
      end
    end
  end

  assign w_addr_p0 = w_ld_gnt_p0 ? bus.i_ld_addr : bus.i_if_addr;
  // Byte offset and bits above the memory size are dropped; addresses wrap.
  assign w_unused_addr_bits = ^{w_addr_p0[31:IDX_W+2], w_addr_p0[1:0]};

  assign bus.o_if_gnt    = w_if_gnt_p0;
  assign bus.o_ld_gnt    = w_ld_gnt_p0;
  assign bus.o_mem_en    = w_if_gnt_p0 | w_ld_gnt_p0;
  assign bus.o_mem_we    = w_ld_gnt_p0 & bus.i_ld_we;
  assign bus.o_mem_addr  = w_addr_p0[IDX_W+1:2];
  assign bus.o_mem_wdata = bus.i_ld_wdata;

  always_comb begin
    w_owner_p0 = OWN_NONE;
    if (w_if_gnt_p0)                         w_owner_p0 = OWN_IF;
    else if (w_ld_gnt_p0 && !bus.i_ld_we)    w_owner_p0 = OWN_LD;
  end

  // ---- p0 -> p1: read ownership and flush history ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner_p1 <= OWN_NONE;
      r_flush_p1 <= 1'b0;
    end else begin
      r_owner_p1 <= w_owner_p0;
      r_flush_p1 <= bus.i_flush;
    end
  end

  // ---- p1: response steering ----
  assign w_if_vld_p1 = (r_owner_p1 == OWN_IF) & ~bus.i_flush & ~r_flush_p1;
  assign w_ld_vld_p1 = (r_owner_p1 == OWN_LD);

  assign bus.o_if_rvalid = w_if_vld_p1;
  assign bus.o_ld_rvalid = w_ld_vld_p1;
  assign bus.o_if_rdata  = w_if_vld_p1 ? bus.i_mem_rdata : 32'h0;
  assign bus.o_ld_rdata  = w_ld_vld_p1 ? bus.i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  localparam int IDX_W = 12;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] mem [4096];

  imem_arbiter_if #(.IDX_W(IDX_W)) bus ();

  imem_arbiter #(
    .DEPTH    (4096),
    .IDX_W    (IDX_W),
    .MAX_WAIT (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port registered-read memory model
  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      else              bus.i_mem_rdata     <= mem[bus.o_mem_addr];
    end
  end

  task automatic idle_inputs();
    bus.i_if_req   = 1'b0;
    bus.i_if_addr  = 32'h0;
    bus.i_flush    = 1'b0;
    bus.i_ld_req   = 1'b0;
    bus.i_ld_we    = 1'b0;
    bus.i_ld_addr  = 32'h0;
    bus.i_ld_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.i_if_req = 1'b1;
    bus.i_ld_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.o_if_gnt !== 1'b0) begin
        errors++; $display("FAIL reset_if_gnt: got %b expected 0", bus.o_if_gnt);
      end
      checks++;
      if (bus.o_ld_gnt !== 1'b0) begin
        errors++; $display("FAIL reset_ld_gnt: got %b expected 0", bus.o_ld_gnt);
      end
      checks++;
      if (bus.o_mem_en !== 1'b0) begin
        errors++; $display("FAIL reset_mem_en: got %b expected 0", bus.o_mem_en);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({bus.o_if_rvalid, bus.o_ld_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid: got %b expected 00", {bus.o_if_rvalid, bus.o_ld_rvalid});
    end
    checks++;
    if ({bus.o_if_rdata, bus.o_ld_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", {bus.o_if_rdata, bus.o_ld_rdata});
    end
  endtask

  task automatic test_fetch_read();
    @(negedge clk);
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0010;
    #1;
    checks++;
    if (bus.o_if_gnt !== 1'b1 || bus.o_mem_en !== 1'b1 || bus.o_mem_we !== 1'b0) begin
      errors++; $display("FAIL fetch_gnt: got gnt=%b en=%b we=%b expected 1 1 0",
                         bus.o_if_gnt, bus.o_mem_en, bus.o_mem_we);
    end
    checks++;
    if (bus.o_mem_addr !== 12'd4) begin
      errors++; $display("FAIL fetch_addr: got %0d expected 4", bus.o_mem_addr);
    end
    @(negedge clk);
    bus.i_if_req = 1'b0;
    #1;
    checks++;
    if (bus.o_if_rvalid !== 1'b1 || bus.o_if_rdata !== 32'h0000_0093) begin
      errors++; $display("FAIL fetch_resp: got rvalid=%b rdata=%h expected 1 00000093",
                         bus.o_if_rvalid, bus.o_if_rdata);
    end
    checks++;
    if (bus.o_ld_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_ld_rvalid: got %b expected 0", bus.o_ld_rvalid);
    end
  endtask

  task automatic test_starvation();
    logic prev_if;
    logic prev_ld;
    logic exp_if;
    logic exp_ld;
    prev_if = 1'b0;
    prev_ld = 1'b0;
    @(negedge clk);
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0010;
    bus.i_ld_req  = 1'b1;
    bus.i_ld_we   = 1'b0;
    bus.i_ld_addr = 32'h0000_0014;
    for (int c = 1; c <= 10; c++) begin
      exp_ld = (c == 5) || (c == 10);
      exp_if = !exp_ld;
      #1;
      checks++;
      if (bus.o_if_gnt !== exp_if || bus.o_ld_gnt !== exp_ld) begin
        errors++; $display("FAIL starve_gnt cycle %0d: got if=%b ld=%b expected if=%b ld=%b",
                           c, bus.o_if_gnt, bus.o_ld_gnt, exp_if, exp_ld);
      end
      if (c > 1) begin
        checks++;
        if (bus.o_if_rvalid !== prev_if || bus.o_ld_rvalid !== prev_ld) begin
          errors++; $display("FAIL starve_rvalid cycle %0d: got if=%b ld=%b expected if=%b ld=%b",
                             c, bus.o_if_rvalid, bus.o_ld_rvalid, prev_if, prev_ld);
        end
      end
      prev_if = exp_if;
      prev_ld = exp_ld;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++;
    if (bus.o_ld_rvalid !== 1'b1 || bus.o_ld_rdata !== 32'h0000_1234 || bus.o_if_rvalid !== 1'b0) begin
      errors++; $display("FAIL starve_last_resp: got ld=%b data=%h if=%b expected 1 00001234 0",
                         bus.o_ld_rvalid, bus.o_ld_rdata, bus.o_if_rvalid);
    end
  endtask

  task automatic test_write_then_fetch();
    @(negedge clk);
    bus.i_ld_req   = 1'b1;
    bus.i_ld_we    = 1'b1;
    bus.i_ld_addr  = 32'h0000_0020;
    bus.i_ld_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.o_ld_gnt !== 1'b1 || bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 12'd8
        || bus.o_mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_drive: got gnt=%b we=%b addr=%0d wdata=%h expected 1 1 8 deadbeef",
                         bus.o_ld_gnt, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
    end
    @(negedge clk);
    idle_inputs();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0020;
    #1;
    checks++;
    if (bus.o_ld_rvalid !== 1'b0 || bus.o_if_gnt !== 1'b1) begin
      errors++; $display("FAIL wr_no_resp: got ld_rvalid=%b if_gnt=%b expected 0 1",
                         bus.o_ld_rvalid, bus.o_if_gnt);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.o_if_rvalid !== 1'b1 || bus.o_if_rdata !== 32'hDEAD_BEEF || bus.o_ld_rvalid !== 1'b0) begin
      errors++; $display("FAIL wr_fetch_data: got rvalid=%b rdata=%h ld_rvalid=%b expected 1 deadbeef 0",
                         bus.o_if_rvalid, bus.o_if_rdata, bus.o_ld_rvalid);
    end
  endtask

  task automatic test_flush();
    // Flush in the response cycle
    @(negedge clk);
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0014;
    @(negedge clk);
    idle_inputs();
    bus.i_flush = 1'b1;
    #1;
    checks++;
    if (bus.o_if_rvalid !== 1'b0 || bus.o_if_rdata !== 32'h0) begin
      errors++; $display("FAIL flush_late: got rvalid=%b rdata=%h expected 0 00000000",
                         bus.o_if_rvalid, bus.o_if_rdata);
    end
    // Flush in the grant cycle: grant and memory read still happen
    @(negedge clk);
    bus.i_flush   = 1'b1;
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0014;
    #1;
    checks++;
    if (bus.o_if_gnt !== 1'b1 || bus.o_mem_en !== 1'b1) begin
      errors++; $display("FAIL flush_gnt: got gnt=%b en=%b expected 1 1", bus.o_if_gnt, bus.o_mem_en);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.o_if_rvalid !== 1'b0 || bus.o_if_rdata !== 32'h0) begin
      errors++; $display("FAIL flush_early: got rvalid=%b rdata=%h expected 0 00000000",
                         bus.o_if_rvalid, bus.o_if_rdata);
    end
  endtask

  task automatic test_ld_read();
    @(negedge clk);
    bus.i_ld_req  = 1'b1;
    bus.i_ld_we   = 1'b0;
    bus.i_ld_addr = 32'h0000_0014;
    @(negedge clk);
    idle_inputs();
    bus.i_flush = 1'b1;
    #1;
    checks++;
    if (bus.o_ld_rvalid !== 1'b1 || bus.o_ld_rdata !== 32'h0000_1234
        || bus.o_if_rvalid !== 1'b0 || bus.o_if_rdata !== 32'h0) begin
      errors++; $display("FAIL ld_read: got ld=%b %h if=%b %h expected 1 00001234 0 00000000",
                         bus.o_ld_rvalid, bus.o_ld_rdata, bus.o_if_rvalid, bus.o_if_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_4004;
    #1;
    checks++;
    if (bus.o_mem_addr !== 12'd1) begin
      errors++; $display("FAIL wrap_addr: got %0d expected 1", bus.o_mem_addr);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.o_if_rvalid !== 1'b1 || bus.o_if_rdata !== 32'hA5A5_0001) begin
      errors++; $display("FAIL wrap_data: got rvalid=%b rdata=%h expected 1 a5a50001",
                         bus.o_if_rvalid, bus.o_if_rdata);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mem[1] <= 32'hA5A5_0001;
    mem[4] <= 32'h0000_0093;
    mem[5] <= 32'h0000_1234;
    test_reset();
    test_fetch_read();
    test_starvation();
    test_write_then_fetch();
    test_flush();
    test_ld_read();
    test_wrap();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
